// File: rtl/arbitro_rr_4x1_pkg.sv
// Shared definitions for the arbitro_rr_4x1 round-robin arbiter slice:
// FSM state encoding, requester count, select width and a one-hot helper.
package arbitro_rr_4x1_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  // OCIOSO: no grant outstanding; CONCEDE: grant held by the current owner
  typedef enum logic [0:0] {
    OCIOSO  = 1'b0,
    CONCEDE = 1'b1
  } estado_t;

  // One-hot grant pattern for a requester index
  function automatic logic [N_REQ-1:0] um_quente(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/arbitro_rr_4x1_prioridade_rr_4.sv
// prioridade_rr_4: combinational rotate-and-priority picker. Scans the
// request vector starting at ptr and wrapping modulo 4; reports whether
// anyone is requesting and the index of the first requester found.
module prioridade_rr_4
  import arbitro_rr_4x1_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valido,
  output logic [SEL_W-1:0] vencedor
);

  logic [SEL_W-1:0] idx_s;

  // Walk offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    valido   = 1'b0;
    vencedor = {SEL_W{1'b0}};
    idx_s    = {SEL_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_s    = ptr + SEL_W'(i);
      vencedor = req[idx_s] ? idx_s : vencedor;
      valido   = valido | req[idx_s];
    end
  end

endmodule

// File: rtl/arbitro_rr_4x1.sv
// arbitro_rr_4x1: round-robin arbiter for a shared 4x1 mux datapath.
// Grants are held until the owner drops its request; one idle turnaround
// cycle always separates two grants. All outputs are registered.
// Optional hold-limit preemption is enabled by defining ARBITRO_LIMITE_EN.
module arbitro_rr_4x1
  import arbitro_rr_4x1_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             ocupado,
  output logic             preempt
);

  estado_t          state_r, state_s;
  logic [SEL_W-1:0] ptr_r, ptr_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic [SEL_W-1:0] sel_r, sel_s;
  logic             ocupado_r, ocupado_s;
  logic             preempt_r, preempt_s;
  logic             valido_s;
  logic [SEL_W-1:0] vencedor_s;

`ifdef ARBITRO_LIMITE_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             outros_s;

  // Another requester is waiting behind the current owner
  always_comb begin
    outros_s = |(req & ~gnt_r);
  end
`endif

  prioridade_rr_4 u_prioridade (
    .req      (req),
    .ptr      (ptr_r),
    .valido   (valido_s),
    .vencedor (vencedor_s)
  );

  // Next-state and next-output decision; sel_r doubles as the owner index
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    gnt_s     = gnt_r;
    sel_s     = sel_r;
    ocupado_s = ocupado_r;
    preempt_s = 1'b0;
`ifdef ARBITRO_LIMITE_EN
    cnt_s     = cnt_r;
`endif
    case (state_r)
      OCIOSO: begin
        if (valido_s) begin
          state_s   = CONCEDE;
          gnt_s     = um_quente(vencedor_s);
          sel_s     = vencedor_s;
          ocupado_s = 1'b1;
          ptr_s     = vencedor_s + 2'd1;
`ifdef ARBITRO_LIMITE_EN
          cnt_s     = {CNT_W{1'b0}};
`endif
        end else begin
          gnt_s     = {N_REQ{1'b0}};
          ocupado_s = 1'b0;
        end
      end
      CONCEDE: begin
        if (!req[sel_r]) begin
          // Normal release; sel keeps the last owner so the mux stays stable
          state_s   = OCIOSO;
          gnt_s     = {N_REQ{1'b0}};
          ocupado_s = 1'b0;
        end
`ifdef ARBITRO_LIMITE_EN
        else if (outros_s && (cnt_r == LIMITE)) begin
          // Hold limit reached with others waiting: revoke the grant
          state_s   = OCIOSO;
          gnt_s     = {N_REQ{1'b0}};
          ocupado_s = 1'b0;
          preempt_s = 1'b1;
        end else if (outros_s) begin
          cnt_s     = cnt_r + CNT_W'(1);
        end
`endif
        else begin
          state_s   = CONCEDE;
        end
      end
      default: begin
        state_s   = OCIOSO;
        gnt_s     = {N_REQ{1'b0}};
        ocupado_s = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= OCIOSO;
      ptr_r     <= {SEL_W{1'b0}};
      gnt_r     <= {N_REQ{1'b0}};
      sel_r     <= {SEL_W{1'b0}};
      ocupado_r <= 1'b0;
      preempt_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      gnt_r     <= gnt_s;
      sel_r     <= sel_s;
      ocupado_r <= ocupado_s;
      preempt_r <= preempt_s;
    end
  end

`ifdef ARBITRO_LIMITE_EN
  // Hold counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end
`endif

  assign gnt     = gnt_r;
  assign sel     = sel_r;
  assign ocupado = ocupado_r;
  assign preempt = preempt_r;

endmodule

// File: tb/tb_arbitro_rr_4x1.sv
// Testbench for arbitro_rr_4x1: directed per-cycle vectors. Each stimulus
// step pushes the outputs expected after the next clock edge; a separate
// monitor pops and compares them just after every rising edge.
module tb_arbitro_rr_4x1;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       ocupado;
    logic       preempt;
  } esp_t;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       ocupado;
  logic       preempt;

  esp_t exp_q[$];
  int   n_checks;
  int   n_pass;
  int   n_vec;

  arbitro_rr_4x1 #(.MAX_HOLD(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .ocupado (ocupado),
    .preempt (preempt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] eg,
                      input logic [1:0] es, input logic eo, input logic ep);
    esp_t e;
    @(negedge clock);
    reset = r;
    req   = q;
    e.gnt = eg;
    e.sel = es;
    e.ocupado = eo;
    e.preempt = ep;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the scoreboard after each edge
  initial begin
    esp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        n_vec++;
        if (gnt === e.gnt && sel === e.sel && ocupado === e.ocupado && preempt === e.preempt) begin
          n_pass++;
        end else begin
          $display("FAIL vec%0d: got gnt=%b sel=%0d ocupado=%b preempt=%b, expected gnt=%b sel=%0d ocupado=%b preempt=%b",
                   n_vec, gnt, sel, ocupado, preempt, e.gnt, e.sel, e.ocupado, e.preempt);
        end
      end
    end
  end

  initial begin
    logic [3:0] um;
    int budget;
    n_checks = 0;
    n_pass   = 0;
    n_vec    = 0;
    reset    = 1'b1;
    req      = 4'b0000;

    // Reset state
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request from requester 2, then release; sel holds 2
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Reset overrides req; then all four request: order 0,1,2,3,0
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int w = 0; w < 5; w++) begin
      um = 4'b0001 << (w % 4);
      step(1'b0, 4'b1111, um, 2'(w % 4), 1'b1, 1'b0);
      step(1'b0, 4'b1111, um, 2'(w % 4), 1'b1, 1'b0);
      step(1'b0, 4'b1111, um, 2'(w % 4), 1'b1, 1'b0);
      step(1'b0, 4'b1111 & ~um, 4'b0000, 2'(w % 4), 1'b0, 1'b0);
    end

    // Owner 1 holds while req[3] toggles; then 3 granted after one idle cycle
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b0, 4'b1000, 4'b0000, 2'd1, 1'b0, 1'b0);
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

    // Pointer wrapped to 0: grant 0, reset mid-grant, re-grant 0
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`ifdef ARBITRO_LIMITE_EN
    // Owner 0 never releases with 1 waiting: revoked after 4 grant cycles
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1);
    step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    // Alone, requester 0 is never preempted
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Owner releases on the limit edge: normal release, no preempt
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
`else
    // No hold limit: owner 0 keeps the grant with 1 waiting
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    // Drain the scoreboard with a bounded wait
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clock);
      #2;
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
